// File: rtl/ifetch_pkg.sv
// Shared encodings for the instruction-fetch stage.
package ifetch_pkg;

    // Next-PC selection coming from the control unit
    typedef enum logic [1:0] {
        NPC_PC4   = 2'b00,
        NPC_PCIMM = 2'b01,
        NPC_JALR  = 2'b10,
        NPC_RSVD  = 2'b11
    } npc_op_e;

    // Fetch FSM states
    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_RSP = 2'd1,
        HOLD     = 2'd2,
        ERR      = 2'd3
    } state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/ifetch_npc_gen.sv
// Combinational next-PC generator with misalignment flag.
module ifetch_npc_gen
    import ifetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic [31:0] imm,
    input  logic [31:0] alu_c,
    output logic [31:0] npc,
    output logic        misalign
);

    // Select the next PC; the reserved encoding falls back to sequential
    always_comb begin
        npc = pc + 32'd4;
        case (npc_op)
            NPC_PCIMM: npc = pc + imm;
            NPC_JALR:  npc = alu_c & ~32'd1;
            default:   npc = pc + 32'd4;
        endcase
        // bit0 is always clear (jalr masks it, others stay aligned), so only bit1 matters
        misalign = npc[1];
    end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: PC register, IROM handshake FSM, retire counter.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      IF_inst,
    output logic [31:0]      IF_pc,
    output logic             if_valid,
    input  logic             ex_done,
    input  logic [1:0]       npc_op,
    input  logic [31:0]      imm,
    input  logic [31:0]      alu_c,
    output logic             fetch_err,
    output logic [CNT_W-1:0] instret
);

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic [31:0]        if_pc_q, if_pc_d;
    logic               valid_q, valid_d;
    logic               req_q, req_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [31:0]        npc;
    logic               misalign;

    // npc is derived from the PC of the instruction currently held for execute
    ifetch_npc_gen u_npc_gen (
        .pc       (if_pc_q),
        .npc_op   (npc_op),
        .imm      (imm),
        .alu_c    (alu_c),
        .npc      (npc),
        .misalign (misalign)
    );

    // FSM next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        if_pc_d   = if_pc_q;
        valid_d   = valid_q;
        err_d     = err_q;
        instret_d = instret_q;
        case (state_q)
            FETCH: begin
                // rvalid deliberately ignored here: drops stale responses after reset
                if (req_q && imem_ready) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    if_pc_d = pc_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ex_done) begin
                    pc_d      = npc;
                    instret_d = instret_q + CNT_W'(1);
                    valid_d   = 1'b0;
                    if (misalign) begin
                        err_d   = 1'b1;
                        inst_d  = NOP;
                        state_d = ERR;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: ; // ERR: only reset leaves
        endcase
        // Registered request: no combinational path from rvalid/ex_done to imem_req
        req_d = (state_d == FETCH);
    end

    // All fetch-stage state, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= NOP;
            if_pc_q   <= RESET_PC;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            err_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            if_pc_q   <= if_pc_d;
            valid_q   <= valid_d;
            req_q     <= req_d;
            err_q     <= err_d;
            instret_q <= instret_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign IF_inst   = inst_q;
    assign IF_pc     = if_pc_q;
    assign if_valid  = valid_q;
    assign fetch_err = err_q;
    assign instret   = instret_q;

endmodule
